// File: rtl/instr_encoder_if.sv
// instr_encoder_if: program-load request/response bundle between a host and instr_encoder.
interface instr_encoder_if #(parameter int AW = 8);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    kind;
  logic [3:0]    alu_op;
  logic          immed;
  logic [2:0]    reg_out;
  logic [2:0]    reg_a;
  logic [2:0]    reg_b;
  logic [4:0]    imm;
  logic [15:0]   instr;
  logic [AW-1:0] instr_addr;
  logic          instr_we;
  logic          done;
  logic          err;
  modport master (
    output start, in_valid, kind, alu_op, immed, reg_out, reg_a, reg_b, imm,
    input  in_ready, instr, instr_addr, instr_we, done, err
  );
  modport slave (
    input  start, in_valid, kind, alu_op, immed, reg_out, reg_a, reg_b, imm,
    output in_ready, instr, instr_addr, instr_we, done, err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded fields into 16-bit words and writes them to sequential addresses.
// Define INSTR_ENCODER_CHECK_EN to flag illegal ALU requests on err instead of encoding them as 5'h1f.
module instr_encoder #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input logic            CLK,
  input logic            reset,
  instr_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;
  state_t        state, state_nx;
  logic [15:0]   instr_q;
  logic [AW-1:0] addr_q;
  logic [4:0]    alu_code, opcode;
  logic          is_alu, alu_bad, bad, imm_form, accept, last;
  logic [15:0]   word;
  always_comb begin
    is_alu   = bus.kind == 2'd0;
    alu_bad  = bus.alu_op == 4'd0 || bus.alu_op > 4'd10 || (bus.immed && bus.alu_op >= 4'd8);
    alu_code = (bus.immed || bus.alu_op >= 4'd8) ? {1'b0, bus.alu_op} + 5'd6 : {1'b0, bus.alu_op} - 5'd1;
    imm_form = is_alu && bus.immed;
`ifdef INSTR_ENCODER_CHECK_EN
    bad      = is_alu && alu_bad;
    opcode   = is_alu ? alu_code : 5'd16 + {3'b000, bus.kind};
`else
    bad      = 1'b0;
    opcode   = !is_alu ? 5'd16 + {3'b000, bus.kind} : alu_bad ? 5'h1f : alu_code;
`endif
    word     = {bus.reg_out, bus.reg_a, imm_form ? bus.imm : {bus.reg_b, 2'b00}, opcode};
  end
  assign accept = bus.in_valid && state == IDLE;
  assign last   = addr_q == AW'(DEPTH - 1);
  always_comb begin
    state_nx = bus.start ? IDLE :
               state == IDLE ? ((accept && !bad) ? WRITE : IDLE) :
               state == WRITE ? (last ? FULL : IDLE) : FULL;
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      addr_q  <= '0;
    end else if (bus.start) begin
      addr_q  <= '0;
    end else begin
      if (accept && !bad) instr_q <= word;
      if (state == WRITE && !last) addr_q <= addr_q + AW'(1);
    end
  end
`ifdef INSTR_ENCODER_CHECK_EN
  logic err_q;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)             err_q <= 1'b0;
    else if (bus.start)    err_q <= 1'b0;
    else if (accept && bad) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
  assign bus.in_ready   = state == IDLE;
  assign bus.instr_we   = state == WRITE;
  assign bus.done       = state == FULL;
  assign bus.instr      = instr_q;
  assign bus.instr_addr = addr_q;
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Builds 16-bit instruction words from decoded fields (ALU op, immediate flag, register indices, immediate value) and writes them sequentially into instruction memory. It is the inverse of the IR opcode decoder: every word it emits decodes back to the same op, immed flag and register fields. It sits between the host/debug program-load path and the instruction RAM, with a valid/ready input handshake and an auto-incrementing write address.

## Interface
- DEPTH, 256: instruction memory words; write address wraps to full at DEPTH-1.
- AW, 8: address width, at least clog2(DEPTH).
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse: clear address, done and err; return to IDLE.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- kind  in  2  0=ALU, 1=BR, 2=STW, 3=LDW.
- alu_op  in  4  ALU op code: IDLE=0, ADD=1, SUB=2, OR=3, AND=4, XOR=5, SL=6, SR=7, GT=8, LT=9, EQ=10.
- immed  in  1  immediate form requested.
- reg_out, reg_a, reg_b  in  3 each  register indices.
- imm  in  5  immediate value.
- instr  out  16  encoded word (registered).
- instr_addr  out  AW  write address.
- instr_we  out  1  one-cycle memory write strobe.
- done  out  1  memory filled; sticky until start/reset.
- err  out  1  illegal request seen; sticky until start/reset.

## Operation
- Word layout: [15:13]=reg_out, [12:10]=reg_a, [9:7]=reg_b (register form) or [9:5]=imm (immediate form), [6:5]=0 in register form, [4:0]=opcode.
- ALU opcode: ADD/SUB/OR/AND/XOR/SL/SR -> 0..6 (register) or 7..13 (immed); GT=14, LT=15, EQ=16 (register only).
- kind BR=17, STW=18, LDW=19, register layout; alu_op and immed ignored.
- Illegal: kind=ALU with alu_op=0, alu_op>10, or immed=1 with GT/LT/EQ.
- States: IDLE (in_ready=1), WRITE (in_ready=0, instr_we=1), FULL (in_ready=0, done=1).
- IDLE: accept when in_valid&&in_ready. Legal -> latch instr, go WRITE. Illegal -> set err, drop, stay IDLE, no address change.
- WRITE: one cycle; at its end instr_addr increments, or if instr_addr==DEPTH-1 it holds and state goes FULL.
- FULL: ignores all requests until start.
- start (any state) has priority: next state IDLE, instr_addr=0, done=0, err=0, instr_we=0; the request on that edge is not accepted.

## Timing
- Reset values: state IDLE, in_ready=1, instr=0, instr_addr=0, instr_we=0, done=0, err=0.
- Accept on edge k -> instr valid and instr_we=1 during cycle k+1 at current instr_addr -> address +1 and in_ready=1 from k+2.
- Throughput one word per two cycles; in_ready is a pure function of state.
- err asserts the cycle after the illegal accept; done asserts the cycle after the last write.
- reset mid-WRITE aborts the write immediately (instr_we drops asynchronously).

## Configuration
- INSTR_ENCODER_CHECK_EN defined: illegal-request detection as above; err functional.
- Undefined: no checking; err tied 0; illegal ALU requests are encoded with opcode 5'b11111 and written as a normal word (address advances).

## Test plan
- ADD r1=r2+r3 (kind 0, alu_op 1, immed 0) after reset -> instr=0x2980 at addr 0, instr_we one cycle, addr=1, in_ready high two cycles after accept.
- SUBI r7=r0-31 (alu_op 2, immed 1, imm 31) -> instr=0xE3E8.
- STW reg_out=1 reg_a=2 reg_b=3 -> instr=0x2992; alu_op/immed ignored.
- GT with immed=1 (check enabled) -> err=1, no instr_we, addr unchanged; start -> err=0, addr=0.
- DEPTH=4, four back-to-back legal requests -> writes at 0..3, done=1, in_ready=0, fifth request ignored; start restores IDLE at addr 0.
- reset asserted during WRITE -> instr_we, instr, instr_addr 0 immediately; subsequent request writes at addr 0.
